// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the two-requester ALU arbiter: datapath and opcode
//   widths, the opcode encoding understood by the downstream ALU pipeline,
//   and the 1-bit requester-ID type carried through the tag FIFO.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/alu_tag_fifo.sv
// ---------------------------------------------------------------------------
// alu_tag_fifo
//   Circular FIFO of requester IDs, one entry per operation issued to the ALU
//   and not yet returned. Head entry routes the next ALU result.
//
//   Ports
//     clk      in   clock, rising edge
//     rst      in   synchronous active-high reset (empties the FIFO)
//     push     in   write push_id at the tail (ignored when full)
//     push_id  in   requester ID of the issued operation
//     pop      in   discard head entry (ignored when empty)
//     head_id  out  requester ID at the head
//     full     out  count == DEPTH
//     empty    out  count == 0
//     count    out  number of valid entries
//
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module alu_tag_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  req_id_e                  push_id,
    input  logic                     pop,
    output req_id_e                  head_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    req_id_e          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage is deliberately not reset; count and pointers alone decide
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = mem[rd_ptr];

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one pipelined ALU between two requesters. At most one request is
//   granted per cycle (round-robin when both are valid), the granted operands
//   are driven to the ALU issue port, and the requester ID is queued in a tag
//   FIFO. Each ALU return pops the head ID and produces a registered
//   one-cycle response pulse for that requester.
//
//   Ports
//     clk, rst                         clock; synchronous active-high reset
//     req{0,1}_valid/_a/_b/_op   in    requester operations
//     req{0,1}_ready             out   grant (combinational)
//     alu_a/_b/_op/_valid_in     out   ALU issue port (zero when idle)
//     alu_result/_zero/_negative/_overflow/_valid_out  in  ALU return port
//     rsp{0,1}_valid             out   one-cycle response pulse
//     rsp_result/_zero/_negative/_overflow  out  last captured ALU outputs
//     busy                       out   operations outstanding
//     err                        out   sticky: ALU return with no tag queued
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_valid_in,

    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_negative,
    input  logic              alu_overflow,
    input  logic              alu_valid_out,

    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_negative,
    output logic              rsp_overflow,

    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    req_id_e           prio;
    logic              grant0;
    logic              grant1;
    req_id_e           grant_id;
    req_id_e           head_id;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  tag_count;
    logic              resp_fire;

    // Grant and issue mux. Credit comes only from the registered count, so a
    // pop in the same cycle cannot make room for a new grant.
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        grant0       = 1'b0;
        grant1       = 1'b0;
        grant_id     = REQ_0;
        alu_a        = '0;
        alu_b        = '0;
        alu_op       = '0;
        alu_valid_in = 1'b0;

        if (!rst && !fifo_full) begin
            grant0 = req0_valid && (!req1_valid || prio == REQ_0);
            grant1 = req1_valid && (!req0_valid || prio == REQ_1);
        end

        if (grant0) begin
            alu_a        = req0_a;
            alu_b        = req0_b;
            alu_op       = req0_op;
            alu_valid_in = 1'b1;
        end else if (grant1) begin
            grant_id     = REQ_1;
            alu_a        = req1_a;
            alu_b        = req1_b;
            alu_op       = req1_op;
            alu_valid_in = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    alu_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (alu_valid_in),
        .push_id (grant_id),
        .pop     (alu_valid_out),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (tag_count)
    );

    // A return is only routed when a tag is waiting; an orphan return flags err.
    assign resp_fire = alu_valid_out && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio         <= REQ_0;
            err          <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            if (grant0) begin
                prio <= REQ_1;
            end else if (grant1) begin
                prio <= REQ_0;
            end

            if (alu_valid_out && fifo_empty) begin
                err <= 1'b1;
            end

            rsp0_valid <= resp_fire && (head_id == REQ_0);
            rsp1_valid <= resp_fire && (head_id == REQ_1);

            if (resp_fire) begin
                rsp_result   <= alu_result;
                rsp_zero     <= alu_zero;
                rsp_negative <= alu_negative;
                rsp_overflow <= alu_overflow;
            end
        end
    end

    assign busy = (tag_count != '0);

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. Contains a behavioural two-stage ALU
//   (issue in cycle T, alu_valid_out in T+2) that can be held off or made to
//   emit an orphan return, and a monitor logging every response pulse.
//   ALU overflow is modelled as unsigned carry (ADD) / borrow (SUB).
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int TAG_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_valid_in;
    logic [15:0] alu_result    = '0;
    logic        alu_zero      = 1'b0;
    logic        alu_negative  = 1'b0;
    logic        alu_overflow  = 1'b0;
    logic        alu_valid_out = 1'b0;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp_result;
    logic        rsp_zero, rsp_negative, rsp_overflow;
    logic        busy, err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic alu_hold   = 1'b0;
    logic alu_inject = 1'b0;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        o;
        int          stamp;
    } alu_ent_t;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        o;
        int          at;
    } rsp_ent_t;

    alu_ent_t alu_q[$];
    rsp_ent_t rsp_log[$];

    always #5 clk = ~clk;

    alu_arbiter #(
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req0_op       (req0_op),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .req1_op       (req1_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_valid_in  (alu_valid_in),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_negative  (alu_negative),
        .alu_overflow  (alu_overflow),
        .alu_valid_out (alu_valid_out),
        .rsp0_valid    (rsp0_valid),
        .rsp1_valid    (rsp1_valid),
        .rsp_result    (rsp_result),
        .rsp_zero      (rsp_zero),
        .rsp_negative  (rsp_negative),
        .rsp_overflow  (rsp_overflow),
        .busy          (busy),
        .err           (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic alu_ent_t alu_calc(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op, input int stamp);
        alu_ent_t    e;
        logic [16:0] w;
        w     = '0;
        e.res = '0;
        e.o   = 1'b0;
        case (op)
            3'b000: begin w = {1'b0, a} + {1'b0, b}; e.res = w[15:0]; e.o = w[16]; end
            3'b001: begin w = {1'b0, a} - {1'b0, b}; e.res = w[15:0]; e.o = w[16]; end
            3'b010: e.res = a & b;
            3'b011: e.res = a | b;
            3'b100: e.res = a ^ b;
            3'b101: e.res = a << b[3:0];
            3'b110: e.res = a >> b[3:0];
            default: e.res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
        endcase
        e.z     = (e.res == 16'd0);
        e.n     = e.res[15];
        e.stamp = stamp;
        return e;
    endfunction

    // Behavioural ALU: an op issued in cycle c is returned during cycle c+2.
    always @(posedge clk) begin
        alu_valid_out <= 1'b0;
        if (alu_inject) begin
            alu_valid_out <= 1'b1;
            alu_result    <= 16'h1234;
            alu_zero      <= 1'b0;
            alu_negative  <= 1'b0;
            alu_overflow  <= 1'b0;
        end else if (alu_q.size() > 0 && !alu_hold && alu_q[0].stamp < cyc) begin
            alu_valid_out <= 1'b1;
            alu_result    <= alu_q[0].res;
            alu_zero      <= alu_q[0].z;
            alu_negative  <= alu_q[0].n;
            alu_overflow  <= alu_q[0].o;
            void'(alu_q.pop_front());
        end
        if (alu_valid_in) begin
            alu_q.push_back(alu_calc(alu_a, alu_b, alu_op, cyc));
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rsp0_valid || rsp1_valid) begin
            check("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 0);
            rsp_log.push_back('{rsp1_valid ? 1 : 0, rsp_result, rsp_zero,
                                rsp_negative, rsp_overflow, cyc});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    endtask

    task automatic set_req0(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic set_req1(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        int grants;

        // ---- reset state, ready gated during reset ----
        rst = 1'b1;
        idle_inputs();
        tick(1);
        set_req0(16'h0001, 16'h0001, OP_ADD);
        set_req1(16'h0002, 16'h0002, OP_ADD);
        #1;
        check("rst_ready0", 32'(req0_ready), 0);
        check("rst_ready1", 32'(req1_ready), 0);
        check("rst_alu_valid_in", 32'(alu_valid_in), 0);
        tick(1);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
        check("rst_rsp_result", 32'(rsp_result), 0);
        check("rst_rsp_flags", 32'({rsp_zero, rsp_negative, rsp_overflow}), 0);
        idle_inputs();
        rst = 1'b0;

        // ---- req0 ADD 3+4 ----
        set_req0(16'h0003, 16'h0004, OP_ADD);
        #1;
        check("add_ready0", 32'(req0_ready), 1);
        check("add_ready1", 32'(req1_ready), 0);
        check("add_alu_valid_in", 32'(alu_valid_in), 1);
        check("add_alu_a", 32'(alu_a), 'h3);
        check("add_alu_b", 32'(alu_b), 'h4);
        check("add_alu_op", 32'(alu_op), 0);
        tick(1);
        idle_inputs();
        #1;
        check("add_busy", 32'(busy), 1);
        check("idle_alu_a", 32'(alu_a), 0);
        tick(2);
        check("add_rsp0_valid", 32'(rsp0_valid), 1);
        check("add_rsp1_valid", 32'(rsp1_valid), 0);
        check("add_result", 32'(rsp_result), 'h7);
        check("add_zero", 32'(rsp_zero), 0);
        tick(1);
        check("add_pulse_end", 32'(rsp0_valid), 0);
        check("add_result_hold", 32'(rsp_result), 'h7);
        check("add_busy_clear", 32'(busy), 0);

        // ---- lone req0 granted although pointer favours req1 ----
        set_req0(16'h00F0, 16'h0F0F, OP_AND);
        #1;
        check("lone_ready0", 32'(req0_ready), 1);
        tick(1);
        idle_inputs();
        tick(2);
        check("and_rsp0_valid", 32'(rsp0_valid), 1);
        check("and_result", 32'(rsp_result), 0);
        check("and_zero", 32'(rsp_zero), 1);
        tick(1);

        // ---- req1 SUB 0-1 ----
        set_req1(16'h0000, 16'h0001, OP_SUB);
        #1;
        check("sub_ready1", 32'(req1_ready), 1);
        check("sub_ready0", 32'(req0_ready), 0);
        check("sub_alu_op", 32'(alu_op), 1);
        tick(1);
        idle_inputs();
        tick(2);
        check("sub_rsp1_valid", 32'(rsp1_valid), 1);
        check("sub_rsp0_valid", 32'(rsp0_valid), 0);
        check("sub_result", 32'(rsp_result), 'hFFFF);
        check("sub_flags_znv", 32'({rsp_zero, rsp_negative, rsp_overflow}), 'b011);
        tick(1);

        // ---- round robin: both valid 4 cycles after reset ----
        apply_reset();
        rsp_log.delete();
        set_req0(16'h0001, 16'h0001, OP_ADD);
        set_req1(16'h00FF, 16'h0F0F, OP_XOR);
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr_ready0_%0d", k), 32'(req0_ready), (k % 2 == 0) ? 1 : 0);
            check($sformatf("rr_ready1_%0d", k), 32'(req1_ready), (k % 2 == 1) ? 1 : 0);
            tick(1);
        end
        idle_inputs();
        tick(5);
        check("rr_rsp_count", 32'(rsp_log.size()), 4);
        for (int k = 0; k < 4 && k < rsp_log.size(); k++) begin
            check($sformatf("rr_rsp_id_%0d", k), 32'(rsp_log[k].id), k % 2);
            check($sformatf("rr_rsp_res_%0d", k), 32'(rsp_log[k].res),
                  (k % 2 == 1) ? 'h0FF0 : 'h0002);
            check($sformatf("rr_rsp_cycle_%0d", k), 32'(rsp_log[k].at), 32'(t0 + 3 + k));
        end

        // ---- tag FIFO full with ALU held off ----
        alu_hold = 1'b1;
        set_req0(16'h0001, 16'h0001, OP_ADD);
        set_req1(16'h00FF, 16'h0F0F, OP_XOR);
        grants = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (req0_ready || req1_ready) grants++;
            tick(1);
        end
        #1;
        check("full_grants", 32'(grants), 4);
        check("full_ready", 32'({req0_ready, req1_ready}), 0);
        check("full_busy", 32'(busy), 1);
        alu_hold = 1'b0;
        tick(1);
        alu_hold = 1'b1;
        #1;
        check("pop_no_credit", 32'({req0_ready, req1_ready}), 0);
        tick(1);
        #1;
        check("pop_grant_next", 32'({req0_ready, req1_ready}), 'b10);
        tick(1);
        idle_inputs();
        alu_hold = 1'b0;
        tick(10);
        check("drain_busy", 32'(busy), 0);
        check("drain_err", 32'(err), 0);

        // ---- orphan ALU return ----
        rsp_log.delete();
        alu_inject = 1'b1;
        tick(1);
        alu_inject = 1'b0;
        tick(1);
        check("orphan_err", 32'(err), 1);
        check("orphan_no_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
        tick(3);
        check("orphan_err_sticky", 32'(err), 1);
        check("orphan_log_empty", 32'(rsp_log.size()), 0);
        check("orphan_result_hold", 32'(rsp_result), 'h0002);
        apply_reset();
        check("err_cleared", 32'(err), 0);

        // ---- reset with two ops in flight ----
        alu_hold = 1'b1;
        set_req0(16'h0001, 16'h0002, OP_OR);
        set_req1(16'h0003, 16'h0004, OP_OR);
        #1;
        check("inflight_ready0", 32'(req0_ready), 1);
        tick(1);
        #1;
        check("inflight_ready1", 32'(req1_ready), 1);
        tick(1);
        check("inflight_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'({req0_ready, req1_ready}), 0);
        check("midrst_alu_valid_in", 32'(alu_valid_in), 0);
        tick(1);
        check("midrst_busy", 32'(busy), 0);
        alu_q.delete();
        rst = 1'b0;
        #1;
        check("post_rst_prio", 32'({req0_ready, req1_ready}), 'b10);
        tick(1);
        idle_inputs();
        alu_hold = 1'b0;
        tick(6);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_err", 32'(err), 0);

        // ---- late ALU return after reset ----
        alu_hold = 1'b1;
        rsp_log.delete();
        set_req1(16'h0005, 16'h0003, OP_SUB);
        tick(1);
        idle_inputs();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("late_busy", 32'(busy), 0);
        check("late_err_before", 32'(err), 0);
        alu_hold = 1'b0;
        tick(4);
        check("late_err", 32'(err), 1);
        check("late_no_rsp", 32'(rsp_log.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TAG_DEPTH, default 4, max issued-but-unreturned ALU operations (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid/req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready/req1_ready  output  1  requester N's operation accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  16  operands per requester.
REQ-007 req0_op, req1_op  input  3  opcode per requester (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110, SLT 111).
REQ-008 alu_a, alu_b  output  16; alu_op  output  3; alu_valid_in  output  1  issue port to the ALU pipeline.
REQ-009 alu_result  input  16; alu_zero, alu_negative, alu_overflow, alu_valid_out  input  1  ALU return port.
REQ-010 rsp0_valid/rsp1_valid  output  1  one-cycle pulse, response for requester N.
REQ-011 rsp_result  output  16; rsp_zero, rsp_negative, rsp_overflow  output  1  shared response data.
REQ-012 busy  output  1  high while any issued operation is unreturned.
REQ-013 err  output  1  sticky protocol error flag.

Function
REQ-014 At most one request SHALL be granted per cycle; reqN_ready = grant to N, combinational from reqN_valid, priority pointer and tag count.
REQ-015 No grant SHALL occur while tag count == TAG_DEPTH; a same-cycle pop gives no credit.
REQ-016 With one valid requester and space, that requester SHALL be granted regardless of pointer.
REQ-017 With both valid, the pointer's requester SHALL be granted; after any grant to N the pointer SHALL move to the other requester; no grant leaves it unchanged.
REQ-018 alu_valid_in SHALL equal (any grant); alu_a/alu_b/alu_op SHALL carry the granted requester's fields, all zero when no grant.
REQ-019 Each grant SHALL push the requester ID (1 bit) into the tag FIFO; each alu_valid_out SHALL pop the head ID.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo TAG_DEPTH.
REQ-021 alu_valid_out with empty FIFO SHALL be ignored for routing, produce no rsp pulse, and set err (held until reset).
REQ-022 One cycle after alu_valid_out, rsp{head ID}_valid SHALL pulse for exactly one cycle and rsp_result/flags SHALL present the registered ALU outputs.
REQ-023 rsp_result/flags SHALL hold last captured value when no response pulses; rsp0_valid and rsp1_valid never both high.
REQ-024 Latency: handshake in cycle T -> alu_valid_out T+2 (ALU pipeline) -> rspN_valid T+3; back-to-back throughput one op per cycle.
REQ-025 Responses SHALL return in issue order; no response backpressure exists.
REQ-026 busy SHALL equal (tag count != 0), registered-state derived.

Reset
REQ-027 On rst: tag FIFO emptied (count, pointers 0), priority pointer = requester 0, err = 0, rsp*_valid = 0, rsp_result = 0, rsp flags = 0, busy = 0.
REQ-028 During rst, reqN_ready and alu_valid_in SHALL be 0.
REQ-029 Reset mid-operation SHALL drop all in-flight tags; a late alu_valid_out after reset SHALL set err per REQ-021.

Structure
REQ-030 Shared package alu_pkg SHALL hold opcode constants, data width 16, opcode width 3, requester-ID type.
REQ-031 Tag FIFO SHALL be one sub-module alu_tag_fifo (parameter DEPTH, 1-bit data, push/pop/full/empty/count).
REQ-032 Arbitration and response registers SHALL reside in alu_arbiter; no combinational path from alu_* inputs to rsp* outputs.

Verification
REQ-033 Only req0 valid, a=0x0003, b=0x0004, op=ADD -> req0_ready same cycle; rsp0_valid at T+3, rsp_result=0x0007, zero=0.
REQ-034 Both valid for 4 cycles after reset -> grants 0,1,0,1; rsp pulses 0,1,0,1 in order.
REQ-035 TAG_DEPTH=4, ALU valid_out held off, both requesting -> exactly 4 grants, then ready low, busy=1; release one valid_out -> next grant following cycle.
REQ-036 alu_valid_out pulse with FIFO empty -> no rsp pulse, err=1 and held until rst.
REQ-037 rst asserted with 2 ops in flight -> next cycle busy=0, ready low during rst, pointer favours req0 afterwards.
REQ-038 req1 SUB a=0x0000, b=0x0001 -> rsp1_valid, rsp_result=0xFFFF, negative=1, overflow=1.
